// File: rtl/serpent_key_schedule_pkg.sv
// Shared Serpent constants: PHI, S-box tables, rotate helper, key-length codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serpent_key_schedule_pkg;

  localparam int          NUM_SUBKEYS = 33;
  localparam logic [5:0]  LAST_K      = 6'(NUM_SUBKEYS - 1);
  localparam logic [31:0] PHI         = 32'h9E37_79B9;

  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;

  // One 64-bit word per S-box; entry x lives in nibble x (bits 4x+3:4x).
  localparam logic [7:0][63:0] SBOX_TABLE = {
    64'h6539AC47B28E0FD1,  // S7
    64'h0A3DF19EB6485C27,  // S6
    64'h176D8E30C9A4B25F,  // S5
    64'hD7E9A4526B0C38F1,  // S4
    64'hE57A421D369C8BF0,  // S3
    64'h25B04E1DFAC39768,  // S2
    64'h43D68EB1A50972CF,  // S1
    64'hC90724DEB56A1F83   // S0
  };

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [3:0] sbox_lookup(input logic [2:0] s, input logic [3:0] x);
    return SBOX_TABLE[s][{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/initial_permutation.sv
// Serpent initial permutation: output bit i takes input bit 32*(i%4) + i/4.
// Latency: combinational.
// Backpressure: none (pure function).
module initial_permutation (
  input  logic [127:0] in_dat,
  output logic [127:0] out_dat
);

  // Pure wiring permutation.
  always_comb begin
    out_dat = '0;
    for (int i = 0; i < 128; i++) begin
      out_dat[i] = in_dat[(i % 4) * 32 + (i / 4)];
    end
  end

endmodule

// File: rtl/serpent_sbox_bitslice.sv
// Applies one selected Serpent S-box across 32 bit-columns of four words.
// Latency: combinational.
// Backpressure: none (pure function).
module serpent_sbox_bitslice
  import serpent_key_schedule_pkg::*;
(
  input  logic [2:0]       sel,
  input  logic [3:0][31:0] words_dat,
  output logic [127:0]     sbox_dat
);

  logic [3:0] y;

  // Column j forms nibble {w3[j],w2[j],w1[j],w0[j]}; output bit b goes to word b.
  always_comb begin
    sbox_dat = '0;
    y        = '0;
    for (int j = 0; j < 32; j++) begin
      y = sbox_lookup(sel, {words_dat[3][j], words_dat[2][j], words_dat[1][j], words_dat[0][j]});
      sbox_dat[j]      = y[0];
      sbox_dat[32 + j] = y[1];
      sbox_dat[64 + j] = y[2];
      sbox_dat[96 + j] = y[3];
    end
  end

endmodule

// File: rtl/serpent_key_schedule.sv
// Expands a 128/192/256-bit key into 33 Serpent subkeys held in a flop register file.
// Latency: one subkey per cycle, valid 33 cycles after start; reads are combinational.
// Backpressure: none; i_start is only honoured in IDLE, otherwise dropped.
module serpent_key_schedule
  import serpent_key_schedule_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic [1:0]   i_key_len,
  input  logic [255:0] i_key,
  input  logic [5:0]   i_address,
  output logic [127:0] o_subkey,
  output logic         o_subkey_valid,
  output logic         o_busy
);

  state_t           state_q, state_d;
  logic             load, last;
  logic [5:0]       k_q;
  logic [7:0][31:0] win_q;
  logic [127:0]     subkey_q [NUM_SUBKEYS];
  logic             valid_q;
  logic [255:0]     padded;
  logic [11:0][31:0] ext;
  logic [2:0]       sbox_sel;
  logic [127:0]     sbox_out, ip_out;

  // Next-state: accept a start only in IDLE, leave GEN after the 33rd subkey.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        load    = 1'b1;
        state_d = GEN;
      end
      GEN: if (k_q == LAST_K) begin
        last    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Pad short keys with a single 1 just above the key, zeros beyond.
  always_comb begin
    padded = i_key;
    case (i_key_len)
      KEY_LEN_128: padded = {127'd0, 1'b1, i_key[127:0]};
      KEY_LEN_192: padded = {63'd0, 1'b1, i_key[191:0]};
      default:     padded = i_key;
    endcase
  end

  // Four chained prekey words per cycle; ext[n] holds w[4k-8+n].
  always_comb begin
    ext[7:0] = win_q;
    for (int n = 0; n < 4; n++) begin
      ext[8 + n] = rotl(ext[n] ^ ext[n + 3] ^ ext[n + 5] ^ ext[n + 7] ^ PHI ^
                        {24'd0, {k_q, 2'b00} + 8'(n)}, 5'd11);
    end
  end

  assign sbox_sel = 3'd3 - k_q[2:0];

  serpent_sbox_bitslice u_sbox (
    .sel       (sbox_sel),
    .words_dat (ext[11:8]),
    .sbox_dat  (sbox_out)
  );

  initial_permutation u_ip (
    .in_dat  (sbox_out),
    .out_dat (ip_out)
  );

  // Window, counter, subkey file and valid flag; reset wipes every subkey.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      k_q     <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_SUBKEYS; i++) subkey_q[i] <= '0;
    end else if (load) begin
      win_q   <= padded;
      k_q     <= '0;
      valid_q <= 1'b0;
    end else if (state_q == GEN) begin
      subkey_q[k_q] <= ip_out;
      win_q         <= ext[11:4];
      if (last) begin
        k_q     <= '0;
        valid_q <= 1'b1;
      end else begin
        k_q <= k_q + 6'd1;
      end
    end
  end

  // Zero-latency read port; out-of-range addresses read as zero.
  always_comb begin
    o_subkey = '0;
    if (i_address < 6'(NUM_SUBKEYS)) o_subkey = subkey_q[i_address];
  end

  assign o_subkey_valid = valid_q;
  assign o_busy         = (state_q == GEN);

endmodule
